tx_segment_sequencer: RTL and testbench
=======================================

Name: tx_segment_sequencer

Overview:
- Packet-level scheduler in the 125 MHz Ethernet TX domain.
- Drives txid, segment_num, byte_data_counter and data_user to the byte builder and the TX memory control stage.
- Walks every segment of a video frame once per redundancy copy: txid 1 over all segments, then txid 2 over all segments, and so on.
- Inserts an inter-packet gap between packets and emits per-packet and per-frame status pulses.

Parameters:
- PKT_LEN, 1500: bytes per packet; byte_data_counter runs 0..PKT_LEN-1; legal range 64..4095.
- DATA_START, 43: first counter value with data_user high.
- DATA_LEN, 1440: number of counter values with data_user high; DATA_START+DATA_LEN <= PKT_LEN.
- IFG, 12: idle cycles between packets; minimum 1.

Ports:
- clk125MHz  in  1  Ethernet TX clock; the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  level; run while high.
- redundancy  in  8  copies per segment; 0 is treated as 1.
- segment_num_max  in  16  segments per frame; 0 is treated as 1.
- oneframe_done  in  1  frame-complete flag from TX memory control.
- txid  out  8  current copy id, 1..redundancy.
- segment_num  out  16  current segment, 0..segment_num_max-1.
- byte_data_counter  out  12  byte index within the current packet.
- data_user  out  1  high while DATA_START <= counter < DATA_START+DATA_LEN, in SEND only.
- tx_en  out  1  high in SEND.
- pkt_start  out  1  one-cycle pulse on counter==0 of each packet.
- pkt_done  out  1  one-cycle pulse on the last byte (counter==PKT_LEN-1).
- frame_start  out  1  pulse coincident with pkt_start when txid==1 and segment_num==0.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (asynchronous on rst_n=0):
  - state=IDLE, txid=1, segment_num=0, byte_data_counter=0.
  - data_user, tx_en, pkt_start, pkt_done, frame_start and busy all 0.
  - Latched redundancy and segment limit cleared to 1.
- Registered outputs. Every output is a flop reflecting the current state and counter.
- IDLE:
  - If en=1, go to SEND next cycle with counter=0.
  - On entry to SEND, pkt_start=1.
- Limit latching:
  - Whenever a packet starts with txid==1 and segment_num==0, latch red_l = max(redundancy,1) and seg_l = max(segment_num_max,1).
  - frame_start=1 on that packet.
  - Limits are held for the whole frame. Input changes mid-frame take effect at the next frame start.
- SEND:
  - Counter increments by 1 each cycle.
  - At counter==PKT_LEN-1: pkt_done=1, then next cycle go to GAP with counter=0 and tx_en=0.
- GAP:
  - Gap counter runs IFG cycles.
  - On the last GAP cycle, advance the indices (below).
  - Then go to SEND if en=1, else IDLE; indices are preserved.
- Index advance (priority order):
  1. If oneframe_done was sampled high during the packet (sticky flag, cleared on advance): txid=1, segment_num=0.
  2. Else if segment_num==seg_l-1: segment_num=0, and txid = (txid==red_l) ? 1 : txid+1.
  3. Else: segment_num+1.
- en deassertion:
  - Dropping en mid-SEND never truncates a packet. The packet and its GAP complete, then the block goes to IDLE.
  - en re-asserted during GAP continues without passing through IDLE.
- Packet spacing: the minimum pkt_start-to-pkt_start period is PKT_LEN+IFG cycles.
- Mid-packet reset: all outputs drop immediately and asynchronously. After release, the block restarts at txid=1, segment 0.
- Width rules:
  - txid arithmetic is 8-bit and never exceeds red_l.
  - segment_num is 16-bit and never exceeds seg_l-1.
  - Counter compares are done at 12 bits.
- Simultaneous events: oneframe_done asserted on the same cycle as the advance counts, because the sticky flag is OR'd with the live input.

Test Plan:
- Reset, then en=1, redundancy=2, segment_num_max=3, small PKT_LEN=80, DATA_START=43, DATA_LEN=20, IFG=12 -> pkt_start every 92 cycles. (txid,seg) sequence: (1,0)(1,1)(1,2)(2,0)(2,1)(2,2)(1,0). frame_start on the 1st and 7th packets.
- Single packet with the same settings -> data_user high exactly for counters 43..62 (20 cycles). tx_en high for 80 cycles. pkt_done at counter 79.
- redundancy=0, segment_num_max=0 -> behaves as 1/1: every packet is (1,0) and every packet asserts frame_start.
- redundancy=1, segment_num_max=150, oneframe_done pulsed during the packet with seg=37 -> next packet is (1,0) with frame_start=1.
- en dropped at counter 10 of a packet -> packet completes to counter 79, GAP of 12 cycles, then IDLE with busy=0. Re-assert en -> next packet uses the advanced indices.
- rst_n asserted at counter 30 -> all outputs 0 in the same cycle. After release and en=1 -> packet (1,0) with frame_start=1.
- Change redundancy from 2 to 3 while at (1,1) -> the current frame still wraps at txid 2. The new limit applies only after the next frame_start.

Source files
------------

// File: rtl/tx_segment_sequencer.sv
// tx_segment_sequencer
// Packet-level scheduler for the 125 MHz Ethernet TX domain. It walks every
// segment of a video frame once per redundancy copy (txid 1 over all segments,
// then txid 2, ...). It inserts an inter-packet gap and emits per-packet and
// per-frame status pulses. Every output is a flop.
module tx_segment_sequencer #(
  parameter int PKT_LEN    = 1500,  // bytes per packet, 64..4095
  parameter int DATA_START = 43,    // first counter value with data_user high
  parameter int DATA_LEN   = 1440,  // counter values with data_user high
  parameter int IFG        = 12     // idle cycles between packets, >= 1
) (
  input  logic        clk125MHz,
  input  logic        rst_n,
  input  logic        en,
  input  logic [7:0]  redundancy,
  input  logic [15:0] segment_num_max,
  input  logic        oneframe_done,
  output logic [7:0]  txid,
  output logic [15:0] segment_num,
  output logic [11:0] byte_data_counter,
  output logic        data_user,
  output logic        tx_en,
  output logic        pkt_start,
  output logic        pkt_done,
  output logic        frame_start,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  // All counter compares are done at the counter's own 12-bit width.
  localparam logic [11:0] CNT_LAST = 12'(PKT_LEN - 1);
  localparam logic [11:0] DU_FIRST = 12'(DATA_START);
  localparam logic [11:0] DU_END   = 12'(DATA_START + DATA_LEN);
  localparam logic [15:0] GAP_LAST = 16'(IFG - 1);

  state_t      state, state_n;
  logic [15:0] gap_cnt, gap_cnt_n;
  logic [7:0]  red_l, red_l_n;          // redundancy held for the whole frame
  logic [15:0] seg_l, seg_l_n;          // segment limit held for the whole frame
  logic        frame_flag, frame_flag_n; // sticky oneframe_done seen this packet

  logic [7:0]  txid_n;
  logic [15:0] segment_num_n;
  logic [11:0] cnt_n;
  logic        start_pkt;
  logic        frame_hit;
  logic        frame_req;

  // Next-state, index advance, limit latching and next output values.
  always_comb begin
    // NOTE: every variable gets a default first so no path can leave one
    // unassigned, which would otherwise infer a latch.
    state_n       = state;
    gap_cnt_n     = gap_cnt;
    red_l_n       = red_l;
    seg_l_n       = seg_l;
    frame_flag_n  = frame_flag;
    txid_n        = txid;
    segment_num_n = segment_num;
    cnt_n         = byte_data_counter;
    start_pkt     = 1'b0;
    // The live input is OR'd in so a flag arriving on the advance cycle counts.
    frame_req     = frame_flag | oneframe_done;

    unique case (state)
      IDLE: begin
        cnt_n     = '0;
        gap_cnt_n = '0;
        if (en) begin
          state_n   = SEND;
          start_pkt = 1'b1;
        end
      end

      SEND: begin
        frame_flag_n = frame_req;
        if (byte_data_counter == CNT_LAST) begin
          state_n   = GAP;
          cnt_n     = '0;
          gap_cnt_n = '0;
        end else begin
          cnt_n = byte_data_counter + 12'd1;
        end
      end

      GAP: begin
        cnt_n        = '0;
        frame_flag_n = frame_req;
        if (gap_cnt == GAP_LAST) begin
          gap_cnt_n    = '0;
          frame_flag_n = 1'b0;
          if (frame_req) begin
            txid_n        = 8'd1;
            segment_num_n = '0;
          end else if (segment_num == seg_l - 16'd1) begin
            segment_num_n = '0;
            txid_n        = (txid == red_l) ? 8'd1 : txid + 8'd1;
          end else begin
            segment_num_n = segment_num + 16'd1;
          end
          if (en) begin
            state_n   = SEND;
            start_pkt = 1'b1;
          end else begin
            state_n = IDLE;
          end
        end else begin
          gap_cnt_n = gap_cnt + 16'd1;
        end
      end

      default: state_n = IDLE;
    endcase

    // A packet starting at (1,0) opens a frame and captures fresh limits.
    frame_hit = start_pkt && (txid_n == 8'd1) && (segment_num_n == 16'd0);
    if (frame_hit) begin
      red_l_n = (redundancy == 8'd0) ? 8'd1 : redundancy;
      seg_l_n = (segment_num_max == 16'd0) ? 16'd1 : segment_num_max;
    end
  end

  // State, counters, latched limits and all registered outputs.
  always_ff @(posedge clk125MHz or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      gap_cnt           <= '0;
      red_l             <= 8'd1;
      seg_l             <= 16'd1;
      frame_flag        <= 1'b0;
      txid              <= 8'd1;
      segment_num       <= '0;
      byte_data_counter <= '0;
      data_user         <= 1'b0;
      tx_en             <= 1'b0;
      pkt_start         <= 1'b0;
      pkt_done          <= 1'b0;
      frame_start       <= 1'b0;
      busy              <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state             <= state_n;
      gap_cnt           <= gap_cnt_n;
      red_l             <= red_l_n;
      seg_l             <= seg_l_n;
      frame_flag        <= frame_flag_n;
      txid              <= txid_n;
      segment_num       <= segment_num_n;
      byte_data_counter <= cnt_n;
      data_user         <= (state_n == SEND) && (cnt_n >= DU_FIRST) && (cnt_n < DU_END);
      tx_en             <= (state_n == SEND);
      pkt_start         <= start_pkt;
      pkt_done          <= (state_n == SEND) && (cnt_n == CNT_LAST);
      frame_start       <= frame_hit;
      busy              <= (state_n != IDLE);
    end
  end

endmodule

// File: tb/tb_tx_segment_sequencer.sv
// Directed testbench for tx_segment_sequencer with a short packet
// (PKT_LEN=80, DATA_START=43, DATA_LEN=20, IFG=12 -> 92-cycle packet period).
// Outputs are sampled on the falling edge.
module tb_tx_segment_sequencer;

  localparam int PKT_LEN    = 80;
  localparam int DATA_START = 43;
  localparam int DATA_LEN   = 20;
  localparam int IFG        = 12;
  localparam int PER        = PKT_LEN + IFG;

  logic        clk125MHz = 1'b0;
  logic        rst_n;
  logic        en;
  logic [7:0]  redundancy;
  logic [15:0] segment_num_max;
  logic        oneframe_done;
  logic [7:0]  txid;
  logic [15:0] segment_num;
  logic [11:0] byte_data_counter;
  logic        data_user, tx_en, pkt_start, pkt_done, frame_start, busy;

  int n_vec = 0;
  int n_err = 0;

  always #4 clk125MHz = ~clk125MHz;

  tx_segment_sequencer #(
    .PKT_LEN(PKT_LEN), .DATA_START(DATA_START), .DATA_LEN(DATA_LEN), .IFG(IFG)
  ) dut (
    .clk125MHz(clk125MHz), .rst_n(rst_n), .en(en),
    .redundancy(redundancy), .segment_num_max(segment_num_max),
    .oneframe_done(oneframe_done), .txid(txid), .segment_num(segment_num),
    .byte_data_counter(byte_data_counter), .data_user(data_user),
    .tx_en(tx_en), .pkt_start(pkt_start), .pkt_done(pkt_done),
    .frame_start(frame_start), .busy(busy)
  );

  task automatic tick(input int n);
    repeat (n) @(negedge clk125MHz);
  endtask

  // Advance falling edges until pkt_start is seen or the budget runs out.
  task automatic wait_start(input int budget, output int cycles, output bit ok);
    cycles = 0;
    ok     = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk125MHz);
      cycles++;
      if (pkt_start === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; redundancy = 8'd2; segment_num_max = 16'd3;
    oneframe_done = 1'b0;
    tick(3);
    n_vec++;
    if ({txid, segment_num, byte_data_counter} !== {8'd1, 16'd0, 12'd0} ||
        {data_user, tx_en, pkt_start, pkt_done, frame_start, busy} !== 6'b0) begin
      n_err++;
      $display("FAIL reset: txid=%0d seg=%0d cnt=%0d flags=%b, expected 1 0 0 000000",
               txid, segment_num, byte_data_counter,
               {data_user, tx_en, pkt_start, pkt_done, frame_start, busy});
    end
    rst_n = 1'b1;
    tick(3);
    n_vec++;
    if (busy !== 1'b0 || tx_en !== 1'b0) begin
      n_err++;
      $display("FAIL idle_en0: busy=%b tx_en=%b, expected 0 0", busy, tx_en);
    end
  endtask

  task automatic test_frame_walk();
    logic [7:0]  etx  [7] = '{8'd1, 8'd1, 8'd1, 8'd2, 8'd2, 8'd2, 8'd1};
    logic [15:0] eseg [7] = '{16'd0, 16'd1, 16'd2, 16'd0, 16'd1, 16'd2, 16'd0};
    logic        efs  [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    int cyc;
    bit ok;
    en = 1'b1;
    for (int p = 0; p < 7; p++) begin
      wait_start(200, cyc, ok);
      n_vec++;
      if (!ok || cyc != ((p == 0) ? 1 : PER)) begin
        n_err++;
        $display("FAIL walk_period[%0d]: seen=%0b after %0d cycles, expected %0d",
                 p, ok, cyc, (p == 0) ? 1 : PER);
      end
      n_vec++;
      if ({txid, segment_num, frame_start} !== {etx[p], eseg[p], efs[p]}) begin
        n_err++;
        $display("FAIL walk_idx[%0d]: (%0d,%0d) fs=%b, expected (%0d,%0d) fs=%b",
                 p, txid, segment_num, frame_start, etx[p], eseg[p], efs[p]);
      end
    end
  endtask

  // Entered on counter 0 of packet (1,0); profiles one packet and its gap.
  task automatic test_packet_shape();
    int du_cnt = 0, du_first = -1, du_last = -1, te_cnt = 0;
    int pd_cnt = 0, pd_at = -1, ps_cnt = 0, cnt_bad = 0, gap_bad = 0;
    for (int i = 0; i < PER; i++) begin
      if (data_user === 1'b1) begin
        du_cnt++;
        if (du_first < 0) du_first = int'(byte_data_counter);
        du_last = int'(byte_data_counter);
      end
      if (tx_en === 1'b1) te_cnt++;
      if (pkt_start === 1'b1) ps_cnt++;
      if (pkt_done === 1'b1) begin
        pd_cnt++;
        pd_at = int'(byte_data_counter);
      end
      if (i < PKT_LEN && byte_data_counter !== 12'(i)) cnt_bad++;
      if (i >= PKT_LEN && (busy !== 1'b1 || tx_en !== 1'b0 || byte_data_counter !== 12'd0))
        gap_bad++;
      tick(1);
    end
    n_vec++;
    if (du_cnt != DATA_LEN || du_first != DATA_START || du_last != DATA_START + DATA_LEN - 1) begin
      n_err++;
      $display("FAIL data_user: %0d cycles %0d..%0d, expected 20 cycles 43..62",
               du_cnt, du_first, du_last);
    end
    n_vec++;
    if (te_cnt != PKT_LEN) begin
      n_err++;
      $display("FAIL tx_en_len: %0d cycles, expected %0d", te_cnt, PKT_LEN);
    end
    n_vec++;
    if (pd_cnt != 1 || pd_at != PKT_LEN - 1) begin
      n_err++;
      $display("FAIL pkt_done: %0d pulses at cnt %0d, expected 1 at 79", pd_cnt, pd_at);
    end
    n_vec++;
    if (ps_cnt != 1 || cnt_bad != 0 || gap_bad != 0) begin
      n_err++;
      $display("FAIL pkt_profile: starts=%0d cnt_errs=%0d gap_errs=%0d, expected 1 0 0",
               ps_cnt, cnt_bad, gap_bad);
    end
    n_vec++;
    if ({pkt_start, txid, segment_num} !== {1'b1, 8'd1, 16'd1}) begin
      n_err++;
      $display("FAIL next_after_shape: start=%b (%0d,%0d), expected 1 (1,1)",
               pkt_start, txid, segment_num);
    end
  endtask

  // Entered on counter 0 of packet (1,1).
  task automatic test_en_drop();
    int cyc;
    bit ok;
    tick(10);
    n_vec++;
    if (byte_data_counter !== 12'd10) begin
      n_err++;
      $display("FAIL drop_cnt10: cnt=%0d, expected 10", byte_data_counter);
    end
    en = 1'b0;
    tick(69);
    n_vec++;
    if (byte_data_counter !== 12'd79 || pkt_done !== 1'b1 || tx_en !== 1'b1) begin
      n_err++;
      $display("FAIL drop_complete: cnt=%0d done=%b tx_en=%b, expected 79 1 1",
               byte_data_counter, pkt_done, tx_en);
    end
    tick(IFG);
    n_vec++;
    if (busy !== 1'b1 || tx_en !== 1'b0) begin
      n_err++;
      $display("FAIL drop_gap: busy=%b tx_en=%b, expected 1 0", busy, tx_en);
    end
    tick(1);
    n_vec++;
    if (busy !== 1'b0 || tx_en !== 1'b0 || pkt_start !== 1'b0) begin
      n_err++;
      $display("FAIL drop_idle: busy=%b tx_en=%b start=%b, expected 0 0 0",
               busy, tx_en, pkt_start);
    end
    tick(5);
    en = 1'b1;
    wait_start(200, cyc, ok);
    n_vec++;
    if (!ok || cyc != 1 || {txid, segment_num, frame_start} !== {8'd1, 16'd2, 1'b0}) begin
      n_err++;
      $display("FAIL drop_resume: seen=%0b cyc=%0d (%0d,%0d) fs=%b, expected 1 1 (1,2) 0",
               ok, cyc, txid, segment_num, frame_start);
    end
  endtask

  // Entered on counter 0 of packet (1,2) with red_l=2; redundancy raised to 3.
  task automatic test_limit_change();
    logic [7:0]  etx  [13] = '{8'd2, 8'd2, 8'd2, 8'd1, 8'd1, 8'd1, 8'd2,
                               8'd2, 8'd2, 8'd3, 8'd3, 8'd3, 8'd1};
    logic [15:0] eseg [13] = '{16'd0, 16'd1, 16'd2, 16'd0, 16'd1, 16'd2, 16'd0,
                               16'd1, 16'd2, 16'd0, 16'd1, 16'd2, 16'd0};
    logic        efs  [13] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
                               1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    int cyc;
    bit ok;
    redundancy = 8'd3;
    for (int p = 0; p < 13; p++) begin
      wait_start(200, cyc, ok);
      n_vec++;
      if (!ok || cyc != PER ||
          {txid, segment_num, frame_start} !== {etx[p], eseg[p], efs[p]}) begin
        n_err++;
        $display("FAIL limit[%0d]: seen=%0b cyc=%0d (%0d,%0d) fs=%b, expected 92 (%0d,%0d) fs=%b",
                 p, ok, cyc, txid, segment_num, frame_start, etx[p], eseg[p], efs[p]);
      end
    end
  endtask

  // Entered on counter 0 of packet (1,0).
  task automatic test_mid_reset();
    int cyc;
    bit ok;
    tick(30);
    n_vec++;
    if (byte_data_counter !== 12'd30 || tx_en !== 1'b1) begin
      n_err++;
      $display("FAIL pre_reset: cnt=%0d tx_en=%b, expected 30 1", byte_data_counter, tx_en);
    end
    #1 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({data_user, tx_en, pkt_start, pkt_done, frame_start, busy} !== 6'b0 ||
        byte_data_counter !== 12'd0 || txid !== 8'd1 || segment_num !== 16'd0) begin
      n_err++;
      $display("FAIL async_reset: flags=%b cnt=%0d (%0d,%0d), expected 000000 0 (1,0)",
               {data_user, tx_en, pkt_start, pkt_done, frame_start, busy},
               byte_data_counter, txid, segment_num);
    end
    redundancy = 8'd0;
    segment_num_max = 16'd0;
    tick(2);
    rst_n = 1'b1;
    wait_start(200, cyc, ok);
    n_vec++;
    if (!ok || cyc != 1 || {txid, segment_num, frame_start} !== {8'd1, 16'd0, 1'b1}) begin
      n_err++;
      $display("FAIL reset_restart: seen=%0b cyc=%0d (%0d,%0d) fs=%b, expected 1 1 (1,0) 1",
               ok, cyc, txid, segment_num, frame_start);
    end
  endtask

  task automatic test_zero_limits();
    int cyc;
    bit ok;
    for (int p = 0; p < 3; p++) begin
      wait_start(200, cyc, ok);
      n_vec++;
      if (!ok || cyc != PER || {txid, segment_num, frame_start} !== {8'd1, 16'd0, 1'b1}) begin
        n_err++;
        $display("FAIL zero_limits[%0d]: seen=%0b cyc=%0d (%0d,%0d) fs=%b, expected 92 (1,0) 1",
                 p, ok, cyc, txid, segment_num, frame_start);
      end
    end
  endtask

  task automatic test_oneframe_done();
    int cyc;
    int bad = 0;
    bit ok;
    redundancy = 8'd1;
    segment_num_max = 16'd150;
    wait_start(200, cyc, ok);  // (1,0): latches 1/150
    for (int s = 1; s <= 37; s++) begin
      wait_start(200, cyc, ok);
      if (!ok || txid !== 8'd1 || segment_num !== 16'(s)) bad++;
    end
    n_vec++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL seg_walk: %0d bad packets, now (%0d,%0d), expected 0 ending (1,37)",
               bad, txid, segment_num);
    end
    tick(5);
    oneframe_done = 1'b1;
    tick(1);
    oneframe_done = 1'b0;
    wait_start(200, cyc, ok);
    n_vec++;
    if (!ok || cyc != PER - 6 || {txid, segment_num, frame_start} !== {8'd1, 16'd0, 1'b1}) begin
      n_err++;
      $display("FAIL ofd_restart: seen=%0b cyc=%0d (%0d,%0d) fs=%b, expected 86 (1,0) 1",
               ok, cyc, txid, segment_num, frame_start);
    end
    wait_start(200, cyc, ok);
    n_vec++;
    if (!ok || {txid, segment_num, frame_start} !== {8'd1, 16'd1, 1'b0}) begin
      n_err++;
      $display("FAIL ofd_cleared: (%0d,%0d) fs=%b, expected (1,1) 0",
               txid, segment_num, frame_start);
    end
    // Flag raised only on the last gap cycle, coinciding with the advance.
    tick(PER - 1);
    oneframe_done = 1'b1;
    wait_start(200, cyc, ok);
    oneframe_done = 1'b0;
    n_vec++;
    if (!ok || cyc != 1 || {txid, segment_num, frame_start} !== {8'd1, 16'd0, 1'b1}) begin
      n_err++;
      $display("FAIL ofd_same_cycle: seen=%0b cyc=%0d (%0d,%0d) fs=%b, expected 1 (1,0) 1",
               ok, cyc, txid, segment_num, frame_start);
    end
  endtask

  initial begin
    test_reset();
    test_frame_walk();
    test_packet_shape();
    test_en_drop();
    test_limit_change();
    test_mid_reset();
    test_zero_limits();
    test_oneframe_done();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
